// File: rtl/traffic_pkg.sv
// Shared traffic-light encodings and the local-road queue state type.
package traffic_pkg;

  localparam logic [2:0] LIGHT_GREEN  = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_RED    = 3'b001;

  typedef enum logic [1:0] {
    EMPTY,
    QUEUED,
    PASSING
  } queue_state_t;

  // A light is legal only when exactly one lamp is lit.
  function automatic logic is_legal_light(input logic [2:0] light);
    return (light == LIGHT_GREEN) || (light == LIGHT_YELLOW) || (light == LIGHT_RED);
  endfunction

endpackage

// File: rtl/lr_car_queue_model_pass_timer.sv
// Counts green cycles for the car currently crossing; tc_c marks the last one.
module pass_timer #(
  parameter int unsigned PASS_CYCLES = 2,
  localparam int unsigned TW = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc_c
);

  logic [TW-1:0] count;

  assign tc_c = (count == TW'(PASS_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc_c ? '0 : count + TW'(1);
    end
  end

endmodule

// File: rtl/lr_car_queue_model.sv
// Local-road car queue: counts arrivals, releases cars on green, flags bad lights.
// Optional statistics outputs are enabled with LR_QUEUE_STATS_EN.
module lr_car_queue_model
  import traffic_pkg::*;
#(
  parameter int unsigned DEPTH       = 15,
  parameter int unsigned PASS_CYCLES = 2,
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          car_arrive,
  input  logic [2:0]    lr_light,
  input  logic [2:0]    hw_light,
  output logic          lr_has_car,
  output logic [CW-1:0] queue_count,
  output logic          car_depart,
  output logic          overflow,
  output logic          light_err
`ifdef LR_QUEUE_STATS_EN
  ,
  output logic [15:0]   served_total,
  output logic [CW-1:0] max_count
`endif
);

  queue_state_t  state;
  logic          green_c;
  logic          timer_en_c;
  logic          timer_tc_c;
  logic          depart_c;
  logic          full_c;
  logic [CW-1:0] next_count_c;

  assign green_c    = (lr_light == LIGHT_GREEN);
  assign timer_en_c = (state == PASSING) && green_c;
  assign depart_c   = timer_en_c && timer_tc_c;
  assign full_c     = (queue_count == CW'(DEPTH));
  assign lr_has_car = (queue_count != '0);

  // Leaving PASSING or losing green restarts the crossing from scratch.
  pass_timer #(
    .PASS_CYCLES(PASS_CYCLES)
  ) u_pass_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!timer_en_c),
    .enable(timer_en_c),
    .tc_c  (timer_tc_c)
  );

  // Arrive and depart on the same edge cancel out; full arrivals are dropped.
  always_comb begin
    next_count_c = queue_count;
    if (depart_c && !car_arrive) begin
      next_count_c = queue_count - CW'(1);
    end else if (!depart_c && car_arrive && !full_c) begin
      next_count_c = queue_count + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      queue_count <= '0;
      car_depart  <= 1'b0;
      overflow    <= 1'b0;
      light_err   <= 1'b0;
    end else begin
      queue_count <= next_count_c;
      car_depart  <= depart_c;
      if (car_arrive && !depart_c && full_c) begin
        overflow <= 1'b1;
      end
      if (!is_legal_light(lr_light) || !is_legal_light(hw_light) ||
          (green_c && (hw_light == LIGHT_GREEN))) begin
        light_err <= 1'b1;
      end
      case (state)
        EMPTY:   if (car_arrive) state <= QUEUED;
        QUEUED:  if (green_c) state <= PASSING;
        PASSING: begin
          if (!green_c) begin
            state <= QUEUED;
          end else if (depart_c && (next_count_c == '0)) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef LR_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      served_total <= '0;
      max_count    <= '0;
    end else begin
      if (depart_c) begin
        served_total <= served_total + 16'(1);
      end
      if (next_count_c > max_count) begin
        max_count <= next_count_c;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lr_car_queue_model.sv
// Directed bench for lr_car_queue_model (DEPTH=15, PASS_CYCLES=2).
module tb_lr_car_queue_model;

  localparam logic [2:0] G = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b001;

  logic       clk = 1'b0;
  logic       rst;
  logic       car_arrive;
  logic [2:0] lr_light;
  logic [2:0] hw_light;
  logic       lr_has_car;
  logic [3:0] queue_count;
  logic       car_depart;
  logic       overflow;
  logic       light_err;
`ifdef LR_QUEUE_STATS_EN
  logic [15:0] served_total;
  logic [3:0]  max_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lr_car_queue_model #(
    .DEPTH      (15),
    .PASS_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .car_arrive  (car_arrive),
    .lr_light    (lr_light),
    .hw_light    (hw_light),
    .lr_has_car  (lr_has_car),
    .queue_count (queue_count),
    .car_depart  (car_depart),
    .overflow    (overflow),
    .light_err   (light_err)
`ifdef LR_QUEUE_STATS_EN
    ,
    .served_total(served_total),
    .max_count   (max_count)
`endif
  );

  typedef struct {
    logic       rst;
    logic       arr;
    logic [2:0] lr;
    logic [2:0] hw;
    int         reps;
    int         cnt;
    logic       has;
    logic       dep;
    logic       ov;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic a, logic [2:0] l, logic [2:0] h, int n,
                              int c, logic hs, logic d, logic o, logic e);
    vec_t v;
    v.rst = r; v.arr = a; v.lr = l; v.hw = h; v.reps = n;
    v.cnt = c; v.has = hs; v.dep = d; v.ov = o; v.err = e;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [2:0] l, input logic [2:0] h);
    rst = r; car_arrive = a; lr_light = l; hw_light = h;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int departs;
    drive(1'b1, 1'b0, R, G);

    // rst arr lr hw reps | cnt has dep ov err
    vecs.push_back(mk(1, 1, G, R, 2,   0, 0, 0, 0, 0));  // reset swallows arrivals
    vecs.push_back(mk(0, 1, R, G, 1,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, R, G, 1,   2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, R, G, 1,   3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, R, G, 20,  3, 1, 0, 0, 0));  // red never releases
    vecs.push_back(mk(0, 0, G, R, 1,   3, 1, 0, 0, 0));  // green edge 1
    vecs.push_back(mk(0, 0, G, R, 1,   3, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, G, R, 1,   2, 1, 1, 0, 0));  // edge 3
    vecs.push_back(mk(0, 0, G, R, 1,   2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, G, R, 1,   1, 1, 1, 0, 0));  // edge 5
    vecs.push_back(mk(0, 0, G, R, 1,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, G, R, 1,   0, 0, 1, 0, 0));  // edge 7
    vecs.push_back(mk(0, 0, G, R, 2,   0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, R, G, 1,   1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, R, G, 1,   2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, G, R, 1,   2, 1, 0, 0, 0));  // one green edge
    vecs.push_back(mk(0, 0, Y, R, 3,   2, 1, 0, 0, 0));  // yellow aborts the pass
    vecs.push_back(mk(0, 0, G, R, 2,   2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, G, R, 1,   2, 1, 1, 0, 0));  // arrive on depart edge
    vecs.push_back(mk(0, 0, G, R, 1,   2, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, G, R, 1,   1, 1, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        drive(vecs[i].rst, vecs[i].arr, vecs[i].lr, vecs[i].hw);
        tick();
        check($sformatf("v%0d.%0d count", i, k), int'(queue_count), vecs[i].cnt);
        check($sformatf("v%0d.%0d has_car", i, k), int'(lr_has_car), int'(vecs[i].has));
        check($sformatf("v%0d.%0d depart", i, k), int'(car_depart), int'(vecs[i].dep));
        check($sformatf("v%0d.%0d overflow", i, k), int'(overflow), int'(vecs[i].ov));
        check($sformatf("v%0d.%0d light_err", i, k), int'(light_err), int'(vecs[i].err));
      end
    end

    // Reset in the middle of a pass: no depart, queue cleared.
    drive(0, 1, R, G); tick();
    drive(0, 0, G, R); tick(); tick();
    drive(1, 0, G, R); tick();
    check("midpass_rst depart", int'(car_depart), 0);
    check("midpass_rst count", int'(queue_count), 0);
    drive(1, 0, G, R); tick();
    check("midpass_rst depart2", int'(car_depart), 0);

    // Overflow saturates at DEPTH and stays sticky through a full drain.
    for (int i = 1; i <= 16; i++) begin
      drive(0, 1, R, G); tick();
      check($sformatf("ovf arr%0d count", i), int'(queue_count), (i > 15) ? 15 : i);
      check($sformatf("ovf arr%0d flag", i), int'(overflow), (i > 15) ? 1 : 0);
    end
    departs = 0;
    for (int i = 0; i < 31; i++) begin
      drive(0, 0, G, R); tick();
      if (car_depart) departs++;
    end
    check("ovf drain departs", departs, 15);
    check("ovf drain count", int'(queue_count), 0);
    check("ovf drain has_car", int'(lr_has_car), 0);
    check("ovf sticky", int'(overflow), 1);

    // Light errors: ignored under reset, sticky after, also caught for non-one-hot.
    drive(1, 0, G, G); tick();
    check("lerr in reset", int'(light_err), 0);
    check("lerr rst clears ovf", int'(overflow), 0);
    drive(0, 0, G, G); tick();
    check("lerr both green", int'(light_err), 1);
    drive(0, 0, R, G); tick();
    check("lerr sticky", int'(light_err), 1);
    drive(1, 0, R, G); tick();
    check("lerr reset clears", int'(light_err), 0);
    drive(0, 0, 3'b110, R); tick();
    check("lerr not onehot", int'(light_err), 1);
    check("lerr count", int'(queue_count), 0);
    drive(0, 0, R, 3'b000); tick();
    check("lerr still set", int'(light_err), 1);

`ifdef LR_QUEUE_STATS_EN
    drive(1, 0, R, G); tick();
    check("stats reset served", int'(served_total), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, R, G); tick();
    end
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, G, R); tick();
    end
    check("stats served_total", int'(served_total), 3);
    check("stats max_count", int'(max_count), 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
